fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 169 ++++++++++++++++
 tb/tb_fetch_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage feeding the IF/ID register.
// Issues word requests to instruction memory, tolerates wait states,
// buffers one instruction while decode stalls, and handles redirects
// (including redirects that land while a request is still in flight).
// Optional build macro FETCH_STAT_EN adds the stat_fetched/stat_stall counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_id,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
`ifdef FETCH_STAT_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_stall
`endif
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DISCARD} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] old_addr, old_addr_nx;
  logic [31:0] hold_instr_p0, hold_instr_nx;
  logic [31:0] instr_p1, instr_nx;
  logic [31:0] pc4_p1, pc4_nx;
  logic        vld_p1, vld_nx;
  logic        req_en;
  logic        xfer;
  logic        load;

  // Next sequential address; wraps naturally at 2^32.
  function automatic logic [31:0] inc4(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // In DISCARD the old (abandoned) address stays on the bus until acked.
  assign inst_req    = req_en && (state != HOLD);
  assign inst_addr   = (state == DISCARD) ? old_addr : pc;
  assign xfer        = inst_req && inst_ack;
  assign id_instr    = instr_p1;
  assign id_pc_plus4 = pc4_p1;
  assign id_valid    = vld_p1;

  // Next-state and IF/ID update; redirect overrides stall and ack.
  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    old_addr_nx   = old_addr;
    hold_instr_nx = hold_instr_p0;
    instr_nx      = instr_p1;
    pc4_nx        = pc4_p1;
    vld_nx        = vld_p1;
    load          = 1'b0;
    if (redirect_valid) begin
      instr_nx      = '0;
      pc4_nx        = '0;
      vld_nx        = 1'b0;
      hold_instr_nx = '0;
      pc_nx         = word_align(redirect_pc);
      if (inst_req && !inst_ack) begin
        // An un-acked request must still be drained; keep its address.
        state_nx = DISCARD;
        if (state != DISCARD) old_addr_nx = pc;
      end else begin
        state_nx = FETCH;
      end
    end else begin
      case (state)
        FETCH, WAIT: begin
          if (xfer) begin
            pc_nx = inc4(pc);
            if (stall_id) begin
              hold_instr_nx = inst_rdata;
              state_nx      = HOLD;
            end else begin
              instr_nx = inst_rdata;
              pc4_nx   = inc4(pc);
              vld_nx   = 1'b1;
              load     = 1'b1;
              state_nx = FETCH;
            end
          end else begin
            if (inst_req) state_nx = WAIT;
            if (!stall_id) begin
              instr_nx = '0;
              pc4_nx   = '0;
              vld_nx   = 1'b0;
            end
          end
        end
        HOLD: begin
          // pc already advanced past the buffered word, so it is its pc+4.
          if (!stall_id) begin
            instr_nx      = hold_instr_p0;
            pc4_nx        = pc;
            vld_nx        = 1'b1;
            load          = 1'b1;
            hold_instr_nx = '0;
            state_nx      = FETCH;
          end
        end
        DISCARD: begin
          if (xfer) state_nx = FETCH;
          if (!stall_id) begin
            instr_nx = '0;
            pc4_nx   = '0;
            vld_nx   = 1'b0;
          end
        end
        default: state_nx = FETCH;
      endcase
    end
  end

  // State, pc, hold buffer and IF/ID registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= FETCH;
      req_en        <= 1'b0;
      pc            <= RESET_PC;
      old_addr      <= RESET_PC;
      hold_instr_p0 <= '0;
      instr_p1      <= '0;
      pc4_p1        <= '0;
      vld_p1        <= 1'b0;
    end else begin
      state         <= state_nx;
      req_en        <= 1'b1;
      pc            <= pc_nx;
      old_addr      <= old_addr_nx;
      hold_instr_p0 <= hold_instr_nx;
      instr_p1      <= instr_nx;
      pc4_p1        <= pc4_nx;
      vld_p1        <= vld_nx;
    end
  end

`ifdef FETCH_STAT_EN
  // Counts delivered instructions and memory wait cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetched <= '0;
      stat_stall   <= '0;
    end else begin
      if (load) stat_fetched <= stat_fetched + 32'd1;
      if (inst_req && !inst_ack) stat_stall <= stat_stall + 32'd1;
    end
  end
`else
  logic unused_load;
  assign unused_load = load;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_id = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
`ifdef FETCH_STAT_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_stall;
`endif

  int checks = 0;
  int failures = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_id(stall_id),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_ack(inst_ack), .inst_rdata(inst_rdata),
    .id_instr(id_instr), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid)
`ifdef FETCH_STAT_EN
    , .stat_fetched(stat_fetched), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    step();
    checks++;
    if ({inst_req, inst_addr} !== {1'b0, 32'h0}) begin
      failures++; $display("FAIL reset_req got=%h exp=%h", {inst_req, inst_addr}, {1'b0, 32'h0});
    end
    checks++;
    if ({id_valid, id_instr, id_pc_plus4} !== 65'h0) begin
      failures++; $display("FAIL reset_ifid got=%h exp=%h", {id_valid, id_instr, id_pc_plus4}, 65'h0);
    end
    @(negedge clk) rst = 1'b1;
    step();
    checks++;
    if ({inst_req, inst_addr} !== {1'b1, 32'h0}) begin
      failures++; $display("FAIL first_req got=%h exp=%h", {inst_req, inst_addr}, {1'b1, 32'h0});
    end
  endtask

  task automatic test_zero_wait();
    inst_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inst_rdata = i * 4;
      step();
      checks++;
      if ({id_valid, id_instr, id_pc_plus4} !== {1'b1, 32'(i * 4), 32'(i * 4 + 4)}) begin
        failures++; $display("FAIL zero_wait_%0d got=%h exp=%h", i, {id_valid, id_instr, id_pc_plus4}, {1'b1, 32'(i * 4), 32'(i * 4 + 4)});
      end
    end
    checks++;
    if (inst_addr !== 32'hC) begin
      failures++; $display("FAIL zero_wait_addr got=%h exp=%h", inst_addr, 32'hC);
    end
`ifdef FETCH_STAT_EN
    checks++;
    if ({stat_fetched, stat_stall} !== {32'd3, 32'd0}) begin
      failures++; $display("FAIL stat_zero_wait got=%h exp=%h", {stat_fetched, stat_stall}, {32'd3, 32'd0});
    end
`endif
  endtask

  task automatic test_wait_states();
    inst_ack = 1'b0;
    step();
    checks++;
    if ({inst_addr, id_valid, id_instr, id_pc_plus4} !== {32'hC, 65'h0}) begin
      failures++; $display("FAIL wait_bubble got=%h exp=%h", {inst_addr, id_valid, id_instr, id_pc_plus4}, {32'hC, 65'h0});
    end
    inst_ack = 1'b1; inst_rdata = 32'hC;
    step();
    inst_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({inst_req, inst_addr, id_valid} !== {1'b1, 32'h10, 1'b0}) begin
        failures++; $display("FAIL wait_hold_%0d got=%h exp=%h", i, {inst_req, inst_addr, id_valid}, {1'b1, 32'h10, 1'b0});
      end
    end
    inst_ack = 1'b1; inst_rdata = 32'hA5A5_0010;
    step();
    checks++;
    if ({id_valid, id_instr, id_pc_plus4, inst_addr} !== {1'b1, 32'hA5A5_0010, 32'h14, 32'h14}) begin
      failures++; $display("FAIL wait_deliver got=%h exp=%h", {id_valid, id_instr, id_pc_plus4, inst_addr}, {1'b1, 32'hA5A5_0010, 32'h14, 32'h14});
    end
  endtask

  task automatic test_stall();
    inst_ack = 1'b1;
    for (int a = 32'h14; a < 32'h20; a += 4) begin
      inst_rdata = 32'(a);
      step();
    end
    stall_id = 1'b1; inst_rdata = 32'hDEAD_0020;
    step();
    checks++;
    if ({inst_req, id_valid, id_instr, id_pc_plus4} !== {1'b0, 1'b1, 32'h1C, 32'h20}) begin
      failures++; $display("FAIL stall_hold got=%h exp=%h", {inst_req, id_valid, id_instr, id_pc_plus4}, {1'b0, 1'b1, 32'h1C, 32'h20});
    end
    inst_ack = 1'b0;
    step();
    checks++;
    if ({inst_req, id_valid, id_instr, id_pc_plus4} !== {1'b0, 1'b1, 32'h1C, 32'h20}) begin
      failures++; $display("FAIL stall_keep got=%h exp=%h", {inst_req, id_valid, id_instr, id_pc_plus4}, {1'b0, 1'b1, 32'h1C, 32'h20});
    end
    stall_id = 1'b0;
    step();
    checks++;
    if ({id_valid, id_instr, id_pc_plus4, inst_req, inst_addr} !== {1'b1, 32'hDEAD_0020, 32'h24, 1'b1, 32'h24}) begin
      failures++; $display("FAIL stall_release got=%h exp=%h", {id_valid, id_instr, id_pc_plus4, inst_req, inst_addr}, {1'b1, 32'hDEAD_0020, 32'h24, 1'b1, 32'h24});
    end
  endtask

  task automatic test_redirect_pending();
    inst_ack = 1'b1;
    for (int a = 32'h24; a < 32'h40; a += 4) begin
      inst_rdata = 32'(a);
      step();
    end
    inst_ack = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    checks++;
    if ({inst_req, inst_addr, id_valid, id_instr, id_pc_plus4} !== {1'b1, 32'h40, 65'h0}) begin
      failures++; $display("FAIL redir_flush got=%h exp=%h", {inst_req, inst_addr, id_valid, id_instr, id_pc_plus4}, {1'b1, 32'h40, 65'h0});
    end
    redirect_valid = 1'b0;
    step();
    checks++;
    if ({inst_req, inst_addr} !== {1'b1, 32'h40}) begin
      failures++; $display("FAIL redir_discard got=%h exp=%h", {inst_req, inst_addr}, {1'b1, 32'h40});
    end
    inst_ack = 1'b1; inst_rdata = 32'h0BAD_0BAD;
    step();
    checks++;
    if ({id_valid, id_instr, inst_req, inst_addr} !== {1'b0, 32'h0, 1'b1, 32'h100}) begin
      failures++; $display("FAIL redir_drop got=%h exp=%h", {id_valid, id_instr, inst_req, inst_addr}, {1'b0, 32'h0, 1'b1, 32'h100});
    end
  endtask

  task automatic test_redirect_stall_ack();
    inst_rdata = 32'h1111_0100;
    step();
    checks++;
    if ({id_valid, id_instr, id_pc_plus4} !== {1'b1, 32'h1111_0100, 32'h104}) begin
      failures++; $display("FAIL rsa_pre got=%h exp=%h", {id_valid, id_instr, id_pc_plus4}, {1'b1, 32'h1111_0100, 32'h104});
    end
    redirect_valid = 1'b1; redirect_pc = 32'h200; stall_id = 1'b1; inst_rdata = 32'h2222_0104;
    step();
    checks++;
    if ({id_valid, id_instr, id_pc_plus4, inst_req, inst_addr} !== {65'h0, 1'b1, 32'h200}) begin
      failures++; $display("FAIL rsa_flush got=%h exp=%h", {id_valid, id_instr, id_pc_plus4, inst_req, inst_addr}, {65'h0, 1'b1, 32'h200});
    end
    redirect_valid = 1'b0; stall_id = 1'b0; inst_ack = 1'b0;
    step();
    checks++;
    if ({inst_req, inst_addr, id_valid} !== {1'b1, 32'h200, 1'b0}) begin
      failures++; $display("FAIL rsa_empty got=%h exp=%h", {inst_req, inst_addr, id_valid}, {1'b1, 32'h200, 1'b0});
    end
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; inst_ack = 1'b1;
    step();
    checks++;
    if (inst_addr !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_setup got=%h exp=%h", inst_addr, 32'hFFFF_FFFC);
    end
    redirect_valid = 1'b0; inst_rdata = 32'h1234_5678;
    step();
    checks++;
    if ({id_valid, id_instr, id_pc_plus4, inst_addr} !== {1'b1, 32'h1234_5678, 32'h0, 32'h0}) begin
      failures++; $display("FAIL wrap got=%h exp=%h", {id_valid, id_instr, id_pc_plus4, inst_addr}, {1'b1, 32'h1234_5678, 32'h0, 32'h0});
    end
  endtask

  task automatic test_discard_retarget();
    inst_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
    step();
    redirect_pc = 32'h405;
    step();
    checks++;
    if ({inst_req, inst_addr} !== {1'b1, 32'h0}) begin
      failures++; $display("FAIL retarget_hold got=%h exp=%h", {inst_req, inst_addr}, {1'b1, 32'h0});
    end
    redirect_valid = 1'b0; inst_ack = 1'b1;
    step();
    checks++;
    if ({inst_addr, id_valid} !== {32'h404, 1'b0}) begin
      failures++; $display("FAIL retarget_new got=%h exp=%h", {inst_addr, id_valid}, {32'h404, 1'b0});
    end
  endtask

  task automatic test_async_reset();
    inst_rdata = 32'h3333_0404;
    step();
    inst_ack = 1'b0; stall_id = 1'b1;
    step();
    checks++;
    if ({id_valid, id_instr, inst_addr} !== {1'b1, 32'h3333_0404, 32'h408}) begin
      failures++; $display("FAIL ar_pre got=%h exp=%h", {id_valid, id_instr, inst_addr}, {1'b1, 32'h3333_0404, 32'h408});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({inst_req, inst_addr, id_valid, id_instr, id_pc_plus4} !== {1'b0, 32'h0, 65'h0}) begin
      failures++; $display("FAIL ar_immediate got=%h exp=%h", {inst_req, inst_addr, id_valid, id_instr, id_pc_plus4}, {1'b0, 32'h0, 65'h0});
    end
`ifdef FETCH_STAT_EN
    checks++;
    if ({stat_fetched, stat_stall} !== 64'h0) begin
      failures++; $display("FAIL ar_stats got=%h exp=%h", {stat_fetched, stat_stall}, 64'h0);
    end
`endif
    inst_ack = 1'b1; inst_rdata = 32'h4444_0408;
    step();
    @(negedge clk) rst = 1'b1;
    step();
    checks++;
    if ({inst_req, inst_addr, id_valid, id_instr} !== {1'b1, 32'h0, 1'b0, 32'h0}) begin
      failures++; $display("FAIL ar_release got=%h exp=%h", {inst_req, inst_addr, id_valid, id_instr}, {1'b1, 32'h0, 1'b0, 32'h0});
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect_pending();
    test_redirect_stall_ack();
    test_discard_retarget();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
